sd_block_loader: RTL and testbench

- Avalon-MM master that drives the sd_reader slave to fetch one 512-byte SD block.
- Sequence per request: check card present, write command argument and READ_BLOCK command, poll status until complete, read the 128-word buffer.
- Output: a byte stream with valid/ready handshake, consumed by the sprite/tile/map RAM loaders.

---
 rtl/sd_loader_pkg.sv | 41 ++++
 rtl/sd_word_serializer.sv | 45 ++++
 rtl/sd_block_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_block_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_loader_pkg.sv
// Shared constants and types for the SD block loader: sd_reader register map,
// status bit positions, error codes and sequencer states.
package sd_loader_pkg;

  localparam logic [7:0]  ADDR_CMD_ARG   = 8'd139;
  localparam logic [7:0]  ADDR_CMD       = 8'd140;
  localparam logic [7:0]  ADDR_ASR       = 8'd141;
  localparam logic [31:0] CMD_READ_BLOCK = 32'd17;

  localparam int unsigned ASR_BIT_PRESENT = 1;
  localparam int unsigned ASR_BIT_BUSY    = 2;
  localparam int unsigned ASR_BIT_TIMEOUT = 3;
  localparam int unsigned ASR_BIT_CRC     = 4;

  localparam logic [6:0] LAST_WORD = 7'd127;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NO_CARD    = 2'd1,
    ERR_SD         = 2'd2,
    ERR_POLL_LIMIT = 2'd3
  } err_code_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ASR0,
    ST_WR_ARG,
    ST_WR_CMD,
    ST_POLL,
    ST_RD_WORD,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Byte address of a block: block * 512, anything above 32 bits is dropped.
  function automatic logic [31:0] block_byte_addr(input logic [22:0] blk);
    return {blk, 9'b0};
  endfunction

endpackage

// File: rtl/sd_word_serializer.sv
// Holds one 32-bit buffer word and hands it out as four little-endian bytes
// over a valid/ready handshake.
module sd_word_serializer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic [1:0]  o_lane,
  output logic        o_last_accepted
);

  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic        valid_q;
  logic        fire;

  assign fire = valid_q & i_ready;

  // Load a fresh word, then step through lanes on each accepted byte.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      word_q  <= i_word;
      lane_q  <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      lane_q <= lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid         = valid_q;
  assign o_data          = word_q[{lane_q, 3'b000} +: 8];
  assign o_lane          = lane_q;
  assign o_last_accepted = fire & (lane_q == 2'd3);

endmodule

// File: rtl/sd_block_loader.sv
// Avalon-MM master that asks the sd_reader slave for one 512-byte block and
// streams the buffer out byte by byte.
//
// state      | meaning
// IDLE       | waiting for i_start
// RD_ASR0    | one status read to confirm a card is present
// WR_ARG     | write block byte address to the command-argument register
// WR_CMD     | write READ_BLOCK to the command register
// POLL       | read status until the command finishes, fails or we give up
// RD_WORD    | read the next 32-bit buffer word
// EMIT       | hand the word's four bytes to the consumer
// DONE       | one-cycle done pulse
// ERROR      | one-cycle error pulse
module sd_block_loader
  import sd_loader_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 2000000,
  parameter int unsigned POLL_W     = 21
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_block_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [1:0]  o_error_code,
  output logic [7:0]  o_avm_address,
  output logic        o_avm_read,
  output logic        o_avm_write,
  output logic [3:0]  o_avm_byteenable,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte_data,
  output logic [8:0]  o_byte_index,
  input  logic        i_byte_ready
);

  state_t            state_q;
  logic              read_q;
  logic              write_q;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic [22:0]       blk_q;
  logic [6:0]        word_q;
  logic [POLL_W-1:0] poll_q;
  logic [POLL_W-1:0] poll_d;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  err_code_t         code_q;

  logic              xfer_done;
  logic              poll_at_limit;
  logic              ser_load;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic [1:0]        ser_lane;
  logic              ser_last;

  // Block numbers above bit 22 would overflow the 32-bit byte address.
  logic              unused_blk_hi;
  assign unused_blk_hi = ^i_block_addr[31:23];

  // An access finishes in the first cycle the slave drops waitrequest.
  assign xfer_done     = (read_q | write_q) & ~i_avm_waitrequest;
  assign poll_d        = poll_q + 1'b1;
  assign poll_at_limit = (poll_d == POLL_W'(POLL_LIMIT));
  assign ser_load      = (state_q == ST_RD_WORD) & xfer_done;

  // Sequencer: state, Avalon strobes and status outputs in one registered block.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      blk_q   <= '0;
      word_q  <= '0;
      poll_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            blk_q   <= i_block_addr[22:0];
            busy_q  <= 1'b1;
            code_q  <= ERR_NONE;
            state_q <= ST_RD_ASR0;
          end
        end
        ST_RD_ASR0: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= ADDR_ASR;
          end else if (xfer_done) begin
            read_q <= 1'b0;
            if (!i_avm_readdata[ASR_BIT_PRESENT]) begin
              code_q  <= ERR_NO_CARD;
              error_q <= 1'b1;
              state_q <= ST_ERROR;
            end else begin
              state_q <= ST_WR_ARG;
            end
          end
        end
        ST_WR_ARG: begin
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_CMD_ARG;
            wdata_q <= block_byte_addr(blk_q);
          end else if (xfer_done) begin
            write_q <= 1'b0;
            state_q <= ST_WR_CMD;
          end
        end
        ST_WR_CMD: begin
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_CMD;
            wdata_q <= CMD_READ_BLOCK;
          end else if (xfer_done) begin
            write_q <= 1'b0;
            poll_q  <= '0;
            state_q <= ST_POLL;
          end
        end
        ST_POLL: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= ADDR_ASR;
          end else if (xfer_done) begin
            read_q <= 1'b0;
            poll_q <= poll_d;
            // A reported SD failure wins even if the busy bit already cleared.
            if (i_avm_readdata[ASR_BIT_TIMEOUT] || i_avm_readdata[ASR_BIT_CRC]) begin
              code_q  <= ERR_SD;
              error_q <= 1'b1;
              state_q <= ST_ERROR;
            end else if (!i_avm_readdata[ASR_BIT_BUSY]) begin
              word_q  <= '0;
              state_q <= ST_RD_WORD;
            end else if (poll_at_limit) begin
              code_q  <= ERR_POLL_LIMIT;
              error_q <= 1'b1;
              state_q <= ST_ERROR;
            end
          end
        end
        ST_RD_WORD: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= {1'b0, word_q};
          end else if (xfer_done) begin
            read_q  <= 1'b0;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (ser_last) begin
            if (word_q == LAST_WORD) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              word_q  <= word_q + 7'd1;
              state_q <= ST_RD_WORD;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sd_word_serializer u_serializer (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_load          (ser_load),
    .i_word          (i_avm_readdata),
    .i_ready         (i_byte_ready),
    .o_valid         (ser_valid),
    .o_data          (ser_data),
    .o_lane          (ser_lane),
    .o_last_accepted (ser_last)
  );

  // Strobes are masked by reset directly so a reset drops them without waiting for the edge.
  assign o_avm_read       = read_q & ~i_reset;
  assign o_avm_write      = write_q & ~i_reset;
  assign o_avm_address    = addr_q;
  assign o_avm_writedata  = wdata_q;
  assign o_avm_byteenable = 4'hF;

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_error_code = code_q;

  assign o_byte_valid = ser_valid;
  assign o_byte_data  = ser_data;
  assign o_byte_index = {word_q, ser_lane};

endmodule

// File: tb/tb_sd_block_loader.sv
// Scoreboard bench for sd_block_loader with a behavioural sd_reader slave.
module tb_sd_block_loader;

  localparam logic [7:0] A_CMD_ARG = 8'd139;
  localparam logic [7:0] A_CMD     = 8'd140;
  localparam logic [7:0] A_ASR     = 8'd141;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] blk_addr;
  logic        o_busy, o_done, o_error;
  logic [1:0]  o_error_code;
  logic [7:0]  o_avm_address;
  logic        o_avm_read, o_avm_write;
  logic [3:0]  o_avm_byteenable;
  logic [31:0] o_avm_writedata;
  logic [31:0] rdata;
  logic        waitreq;
  logic        o_byte_valid;
  logic [7:0]  o_byte_data;
  logic [8:0]  o_byte_index;
  logic        ready;

  always #5 clk = ~clk;

  sd_block_loader #(.POLL_LIMIT(8), .POLL_W(21)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_block_addr      (blk_addr),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_error_code      (o_error_code),
    .o_avm_address     (o_avm_address),
    .o_avm_read        (o_avm_read),
    .o_avm_write       (o_avm_write),
    .o_avm_byteenable  (o_avm_byteenable),
    .o_avm_writedata   (o_avm_writedata),
    .i_avm_readdata    (rdata),
    .i_avm_waitrequest (waitreq),
    .o_byte_valid      (o_byte_valid),
    .o_byte_data       (o_byte_data),
    .o_byte_index      (o_byte_index),
    .i_byte_ready      (ready)
  );

  typedef struct packed { logic wr; logic [7:0] addr; logic [31:0] data; } txn_t;
  typedef struct packed { logic [8:0] idx; logic [7:0] data; } byte_t;
  typedef struct packed { logic is_err; logic [1:0] code; } out_t;

  txn_t  exp_txn[$];
  byte_t exp_byte_q[$];
  out_t  exp_out[$];

  int checks = 0;
  int errors = 0;

  int wait_cfg = 0, ready_pct = 100, inprog_cfg = 0, errpoll_cfg = 0;
  bit card_cfg = 1'b1, stuck_cfg = 1'b0, cmd_seen = 1'b0;
  int wait_left = 0, poll_n = 0, cur_blk = 0;
  int bytes_seen = 0, pulses = 0, pulses_at_launch = 0;

  function automatic logic [7:0] model_byte(input int blk, input int i);
    return 8'(i * 13 + blk * 37 + i / 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Slave model: fixed waitrequest stretch, ASR behaviour set per test.
  initial begin : slave
    waitreq = 1'b0;
    rdata   = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (rst || !(o_avm_read || o_avm_write)) begin
        waitreq   = 1'b0;
        rdata     = 32'hDEAD_BEEF;
        wait_left = wait_cfg;
      end else if (wait_left > 0) begin
        waitreq = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        wait_left--;
      end else begin
        waitreq = 1'b0;
        if (o_avm_write) begin
          if (o_avm_address == A_CMD_ARG) cur_blk = int'(o_avm_writedata >> 9);
          if (o_avm_address == A_CMD) begin
            cmd_seen = 1'b1;
            poll_n   = 0;
          end
        end else if (o_avm_address == A_ASR) begin
          rdata    = 32'd0;
          rdata[1] = card_cfg;
          if (cmd_seen) begin
            poll_n++;
            if (stuck_cfg || poll_n <= inprog_cfg) rdata[2] = 1'b1;
            if (poll_n == errpoll_cfg) rdata[4] = 1'b1;
          end
        end else if (o_avm_address < 8'd128) begin
          for (int k = 0; k < 4; k++)
            rdata[8*k +: 8] = model_byte(cur_blk, 4 * int'(o_avm_address) + k);
        end else begin
          rdata = 32'd0;
        end
      end
    end
  end

  // Consumer ready, changed just after each rising edge.
  initial begin : consumer
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer, byte or pulse.
  initial begin : monitor
    logic       prev_wait, prev_rd, prev_wr, prev_stall;
    logic [7:0] prev_addr, prev_data;
    logic [31:0] prev_wdata;
    logic [8:0] prev_idx;
    txn_t  t;
    byte_t b;
    out_t  o;
    prev_wait = 0; prev_stall = 0;
    prev_rd = 0; prev_wr = 0; prev_addr = 0; prev_wdata = 0; prev_data = 0; prev_idx = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_wait  = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_wait) begin
        check("hold_read", o_avm_read, prev_rd);
        check("hold_write", o_avm_write, prev_wr);
        check("hold_addr", o_avm_address, prev_addr);
        check("hold_wdata", o_avm_writedata, prev_wdata);
      end
      if (o_avm_read || o_avm_write) check("one_strobe", o_avm_read & o_avm_write, 1'b0);
      if (o_avm_read) check("read_while_bytes", o_byte_valid, 1'b0);
      if ((o_avm_read || o_avm_write) && !waitreq) begin
        if (exp_txn.size() == 0) begin
          fail_now("extra_avm_txn", $sformatf("got wr=%0d addr=%0d, expected none", o_avm_write, o_avm_address));
        end else begin
          t = exp_txn.pop_front();
          check("txn_kind", o_avm_write, t.wr);
          check("txn_addr", o_avm_address, t.addr);
          if (t.wr) check("txn_wdata", o_avm_writedata, t.data);
        end
      end
      prev_wait  = (o_avm_read || o_avm_write) && waitreq;
      prev_rd    = o_avm_read;
      prev_wr    = o_avm_write;
      prev_addr  = o_avm_address;
      prev_wdata = o_avm_writedata;

      if (prev_stall) begin
        check("stall_valid", o_byte_valid, 1'b1);
        check("stall_data", o_byte_data, prev_data);
        check("stall_index", o_byte_index, prev_idx);
      end
      if (o_byte_valid && ready) begin
        bytes_seen++;
        check("busy_in_stream", o_busy, 1'b1);
        if (exp_byte_q.size() == 0) begin
          fail_now("extra_byte", $sformatf("got idx %0d, expected none", o_byte_index));
        end else begin
          b = exp_byte_q.pop_front();
          check("byte_index", o_byte_index, b.idx);
          check("byte_data", o_byte_data, b.data);
        end
      end
      prev_stall = o_byte_valid && !ready;
      prev_data  = o_byte_data;
      prev_idx   = o_byte_index;

      if (o_done || o_error) begin
        pulses++;
        if (exp_out.size() == 0) begin
          fail_now("extra_outcome", $sformatf("got done=%0d error=%0d, expected none", o_done, o_error));
        end else begin
          o = exp_out.pop_front();
          check("outcome_error", o_error, o.is_err);
          check("outcome_done", o_done, !o.is_err);
          check("outcome_code", o_error_code, o.code);
          check("busy_at_pulse", o_busy, 1'b1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_error"}, o_error, 1'b0);
    check({tag, "_code"}, o_error_code, 2'd0);
    check({tag, "_addr"}, o_avm_address, 8'd0);
    check({tag, "_read"}, o_avm_read, 1'b0);
    check({tag, "_write"}, o_avm_write, 1'b0);
    check({tag, "_be"}, o_avm_byteenable, 4'hF);
    check({tag, "_wdata"}, o_avm_writedata, 32'd0);
    check({tag, "_bvalid"}, o_byte_valid, 1'b0);
    check({tag, "_bdata"}, o_byte_data, 8'd0);
    check({tag, "_bindex"}, o_byte_index, 9'd0);
  endtask

  task automatic launch(input logic [31:0] blk, input logic [31:0] arg_exp, input bit card,
                        input int inprog, input int errpoll, input bit stuck);
    card_cfg    = card;
    inprog_cfg  = inprog;
    errpoll_cfg = errpoll;
    stuck_cfg   = stuck;
    cmd_seen    = 1'b0;
    poll_n      = 0;
    exp_txn.push_back('{1'b0, A_ASR, 32'd0});
    if (!card) begin
      exp_out.push_back('{1'b1, 2'd1});
    end else begin
      exp_txn.push_back('{1'b1, A_CMD_ARG, arg_exp});
      exp_txn.push_back('{1'b1, A_CMD, 32'd17});
      if (errpoll > 0) begin
        for (int i = 0; i < errpoll; i++) exp_txn.push_back('{1'b0, A_ASR, 32'd0});
        exp_out.push_back('{1'b1, 2'd2});
      end else if (stuck) begin
        for (int i = 0; i < 8; i++) exp_txn.push_back('{1'b0, A_ASR, 32'd0});
        exp_out.push_back('{1'b1, 2'd3});
      end else begin
        for (int i = 0; i <= inprog; i++) exp_txn.push_back('{1'b0, A_ASR, 32'd0});
        for (int w = 0; w < 128; w++) exp_txn.push_back('{1'b0, 8'(w), 32'd0});
        for (int i = 0; i < 512; i++) exp_byte_q.push_back('{9'(i), model_byte(int'(arg_exp >> 9), i)});
        exp_out.push_back('{1'b0, 2'd0});
      end
    end
    pulses_at_launch = pulses;
    @(posedge clk);
    #1;
    start    = 1'b1;
    blk_addr = blk;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_case(input string name, input logic [1:0] code_exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (pulses > pulses_at_launch) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now({name, "_timeout"}, "got no done/error pulse, expected one");
    end else begin
      #2;
      check({name, "_busy_after"}, o_busy, 1'b0);
      check({name, "_code_held"}, o_error_code, code_exp);
    end
    check({name, "_txn_left"}, exp_txn.size(), 0);
    check({name, "_bytes_left"}, exp_byte_q.size(), 0);
    check({name, "_outcome_left"}, exp_out.size(), 0);
    exp_txn.delete();
    exp_byte_q.delete();
    exp_out.delete();
  endtask

  task automatic wait_bytes(input string name, input int n);
    int b0;
    bit ok;
    b0 = bytes_seen;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (bytes_seen - b0 >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name, $sformatf("got %0d bytes, expected %0d", bytes_seen - b0, n));
  endtask

  initial begin : main
    rst      = 1'b1;
    start    = 1'b0;
    blk_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    launch(32'd3, 32'h0000_0600, 1'b0, 0, 0, 1'b0);
    finish_case("no_card", 2'd1);

    launch(32'd5, 32'h0000_0A00, 1'b1, 3, 0, 1'b0);
    finish_case("nominal", 2'd0);

    launch(32'hFF80_0001, 32'h0000_0200, 1'b1, 0, 0, 1'b0);
    finish_case("trunc", 2'd0);

    wait_cfg = 4;
    launch(32'd9, 32'h0000_1200, 1'b1, 2, 0, 1'b0);
    finish_case("waitreq", 2'd0);

    wait_cfg  = 1;
    ready_pct = 30;
    launch(32'd2, 32'h0000_0400, 1'b1, 1, 0, 1'b0);
    finish_case("backpressure", 2'd0);
    wait_cfg  = 0;
    ready_pct = 100;

    launch(32'd11, 32'h0000_1600, 1'b1, 1, 2, 1'b0);
    finish_case("sd_error", 2'd2);

    launch(32'd12, 32'h0000_1800, 1'b1, 0, 0, 1'b1);
    finish_case("poll_limit", 2'd3);

    launch(32'd6, 32'h0000_0C00, 1'b1, 1, 0, 1'b0);
    wait_bytes("midrst_wait", 200);
    #1;
    rst = 1'b1;
    exp_txn.delete();
    exp_byte_q.delete();
    exp_out.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #2;
    check_reset_outputs("midrst");
    launch(32'd7, 32'h0000_0E00, 1'b1, 0, 0, 1'b0);
    finish_case("after_rst", 2'd0);

    launch(32'd4, 32'h0000_0800, 1'b1, 2, 0, 1'b0);
    wait_bytes("busy_wait", 100);
    #1;
    start    = 1'b1;
    blk_addr = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_case("busy_start", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
